johnson_decoder: RTL and testbench
==================================

// Module: johnson_decoder
// PURPOSE
//  Reader side of the Johnson counter: samples an N-stage Johnson code, decodes it to a
//  phase index and one-hot vector, and checks that successive samples form a legal sequence.
//  Flags illegal codes, holds, single steps and skips, counts errors and reports lock.
//  Sits downstream of the Johnson counter outputs, in the same CLK domain.
// PARAMETERS
//  N          4   Johnson stages (code width). Legal range N >= 2. Sequence length 2N.
//  LOCK_STEPS 4   consecutive forward steps needed to declare lock (>= 1)
//  ERR_W      8   width of the saturating error counter
//  PW         derived = $clog2(2N), phase width (localparam)
// PORTS
//  CLK      in   1      clock, all logic on rising edge
//  CLR      in   1      reset, synchronous, active-high
//  EN       in   1      sample strobe; q is captured on an edge where EN=1
//  q        in   N      Johnson code; q[0] is the stage fed by ~q[N-1]
//  phase    out  PW     last legal decoded phase, 0..2N-1
//  onehot   out  2N     onehot[phase] for a legal sample; all-zero for an illegal sample
//  valid    out  1      1-cycle pulse: result of a new sample is present
//  illegal  out  1      sample was not a Johnson code (qualified by valid)
//  step     out  1      phase == previous phase + 1 mod 2N (qualified by valid)
//  hold     out  1      phase == previous phase (qualified by valid)
//  skip     out  1      legal but neither step nor hold, backward included (qualified by valid)
//  locked   out  1      lock FSM is in LOCKED
//  err_cnt  out  ERR_W  saturating count of illegal + skip samples
// BEHAVIOUR
//  Reset: CLR=1 at an edge clears all outputs to 0, FSM=UNLOCKED, reference invalid,
//   run counter 0. CLR has priority; a sample with EN=1 in the same cycle is discarded.
//  Legal codes: k ones contiguous from q[0] (phase k, 0..N), or contiguous ones from q[N-1]
//   (phase 2N-popcount). Decode: q[N-1]=0 -> phase=popcount(q); else phase=2N-popcount(q).
//   Legal iff adjacent bits of q differ at most once. N=4: 0000=0, 0001=1, 0011=2, 0111=3,
//   1111=4, 1110=5, 1100=6, 1000=7.
//  Latency: 1 cycle. Results are registered on the EN edge and visible the following cycle.
//   valid is high exactly 1 cycle per sample. illegal/step/hold/skip are 0 whenever valid=0.
//   With EN=0, no output or state changes except valid dropping to 0.
//  Per sample (EN=1, CLR=0):
//   - illegal: illegal=1, onehot=0, phase holds, reference invalidated, err_cnt+1.
//   - legal, no reference (first after reset/illegal): phase/onehot update. No step/hold/skip.
//     The sample becomes the reference.
//   - legal with reference: exactly one of hold/step/skip. Wrap 2N-1 -> 0 counts as step.
//     skip -> err_cnt+1. Reference <= new phase.
//  err_cnt saturates at 2^ERR_W-1. Never wraps.
//  Lock FSM (updates on the same edge as the sample result):
//   UNLOCKED: legal sample -> ACQUIRE, run=0. Illegal -> stay.
//   ACQUIRE:  step -> run+1; run reaching LOCK_STEPS -> LOCKED. hold -> stay, run kept.
//             skip or illegal -> UNLOCKED.
//   LOCKED:   step/hold -> stay. skip or illegal -> UNLOCKED (locked drops in the cycle valid=1).
//  Lock is evaluated only on samples, never on idle cycles.
// TESTING
//  1 CLR=1 for 2 cycles, arbitrary q/EN -> all outputs 0, locked=0, err_cnt=0.
//  2 N=4, LOCK_STEPS=4, EN=1 each cycle, q=0000,0001,0011,0111,1111,1110,1100,1000,0000
//    -> phase 0..7,0. step=1 from sample 2 on, incl. 7->0. locked=1 with sample 5's valid.
//  3 Locked, q=0101 -> valid=1, illegal=1, onehot=0, phase holds 3, err_cnt=1, locked=0.
//    Then 0111 -> no step/hold/skip flag (fresh reference).
//  4 Ref phase 2 (0011), q=1111 -> skip=1, err_cnt+1. Ref phase 3, q=0011 -> skip=1 (backward).
//  5 q=0111 sampled twice with 3 idle EN=0 cycles between -> hold=1. valid=0 and no change
//    in the idle cycles.
//  6 ERR_W=2, 5 illegal samples -> err_cnt=3 (saturated). CLR=1 with EN=1 -> all cleared,
//    no valid.

Source files
------------

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code sampler: phase/one-hot decode, sequence checking, lock FSM.
module johnson_decoder #(
   parameter int N          = 4,
   parameter int LOCK_STEPS = 4,
   parameter int ERR_W      = 8,
   localparam int PW        = $clog2(2 * N)
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             EN,
   input  logic [N-1:0]     q,
   output logic [PW-1:0]    phase,
   output logic [2*N-1:0]   onehot,
   output logic             valid,
   output logic             illegal,
   output logic             step,
   output logic             hold,
   output logic             skip,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int RW = $clog2(LOCK_STEPS + 1);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [RW-1:0]    run_q, run_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [2*N-1:0]   onehot_q, onehot_d;
   logic             ref_ok_q, ref_ok_d;
   logic             valid_q, valid_d;
   logic             illegal_q, illegal_d;
   logic             step_q, step_d;
   logic             hold_q, hold_d;
   logic             skip_q, skip_d;
   logic [ERR_W-1:0] err_q, err_d;

   logic             legal;
   logic [PW-1:0]    dec_phase;
   logic [PW-1:0]    next_phase;
   logic             is_step, is_hold, is_skip;
   int               pc;
   int               edges;

   // A Johnson code has at most one boundary between a run of ones and a run of zeros.
   always_comb begin
      pc    = 0;
      edges = 0;
      for (int i = 0; i < N; i++) begin
         pc = pc + int'(q[i]);
      end
      for (int i = 0; i < N - 1; i++) begin
         edges = edges + int'(q[i] ^ q[i+1]);
      end
      legal     = (edges <= 1);
      dec_phase = q[N-1] ? PW'(2 * N - pc) : PW'(pc);
   end

   always_comb begin
      next_phase = (phase_q == PW'(2 * N - 1)) ? '0 : phase_q + PW'(1);
      is_hold    = ref_ok_q && (dec_phase == phase_q);
      is_step    = ref_ok_q && (dec_phase == next_phase);
      is_skip    = ref_ok_q && !is_hold && !is_step;
   end

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      phase_d   = phase_q;
      onehot_d  = onehot_q;
      ref_ok_d  = ref_ok_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      step_d    = 1'b0;
      hold_d    = 1'b0;
      skip_d    = 1'b0;
      if (EN) begin
         valid_d = 1'b1;
         if (!legal) begin
            illegal_d = 1'b1;
            onehot_d  = '0;
            ref_ok_d  = 1'b0;
            state_d   = UNLOCKED;
            if (!(&err_q)) err_d = err_q + ERR_W'(1);
         end else begin
            phase_d  = dec_phase;
            onehot_d = {{(2*N-1){1'b0}}, 1'b1} << dec_phase;
            ref_ok_d = 1'b1;
            step_d   = is_step;
            hold_d   = is_hold;
            skip_d   = is_skip;
            if (is_skip && !(&err_q)) err_d = err_q + ERR_W'(1);
            case (state_q)
               UNLOCKED: begin
                  state_d = ACQUIRE;
                  run_d   = '0;
               end
               ACQUIRE: begin
                  if (is_step) begin
                     run_d = run_q + RW'(1);
                     if (run_q + RW'(1) == RW'(LOCK_STEPS)) state_d = LOCKED;
                  end else if (is_skip) begin
                     state_d = UNLOCKED;
                  end
               end
               LOCKED: begin
                  if (is_skip) state_d = UNLOCKED;
               end
               default: state_d = UNLOCKED;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q   <= UNLOCKED;
         run_q     <= '0;
         phase_q   <= '0;
         onehot_q  <= '0;
         ref_ok_q  <= 1'b0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         step_q    <= 1'b0;
         hold_q    <= 1'b0;
         skip_q    <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         phase_q   <= phase_d;
         onehot_q  <= onehot_d;
         ref_ok_q  <= ref_ok_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         step_q    <= step_d;
         hold_q    <= hold_d;
         skip_q    <= skip_d;
         err_q     <= err_d;
      end
   end

   assign phase   = phase_q;
   assign onehot  = onehot_q;
   assign valid   = valid_q;
   assign illegal = illegal_q;
   assign step    = step_q;
   assign hold    = hold_q;
   assign skip    = skip_q;
   assign locked  = (state_q == LOCKED);
   assign err_cnt = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - Directed vector table plus randomized checks against a sequence model.
module tb_johnson_decoder;

   logic       CLK = 1'b0;
   logic       CLR = 1'b1;
   logic       EN  = 1'b0;
   logic [3:0] q   = '0;

   logic [2:0] phase;
   logic [7:0] onehot;
   logic       valid, illegal, step, hold, skip, locked;
   logic [7:0] err_cnt;

   logic [2:0] phase2;
   logic [7:0] onehot2;
   logic       valid2, illegal2, step2, hold2, skip2, locked2;
   logic [1:0] err_cnt2;

   always #5 CLK = ~CLK;

   johnson_decoder #(.N(4), .LOCK_STEPS(4), .ERR_W(8)) u_dut (
      .CLK(CLK), .CLR(CLR), .EN(EN), .q(q),
      .phase(phase), .onehot(onehot), .valid(valid), .illegal(illegal),
      .step(step), .hold(hold), .skip(skip), .locked(locked), .err_cnt(err_cnt)
   );

   johnson_decoder #(.N(4), .LOCK_STEPS(4), .ERR_W(2)) u_dut_sat (
      .CLK(CLK), .CLR(CLR), .EN(EN), .q(q),
      .phase(phase2), .onehot(onehot2), .valid(valid2), .illegal(illegal2),
      .step(step2), .hold(hold2), .skip(skip2), .locked(locked2), .err_cnt(err_cnt2)
   );

   typedef struct {
      logic       clr, en;
      logic [3:0] qv;
      logic [2:0] ph;
      logic [7:0] oh;
      logic       v, il, st, ho, sk, lk;
      logic [7:0] err;
      logic [1:0] err2;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model: legal codes listed in sequence order, matched by lookup.
   int   code_tab[8];
   int   m_ph, m_oh, m_v, m_il, m_st, m_ho, m_sk, m_state, m_run, m_ref_ok, m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic row(input logic clr, en, input logic [3:0] qv, input logic [2:0] ph,
                      input logic [7:0] oh, input logic v, il, st, ho, sk, lk,
                      input logic [7:0] err, input logic [1:0] err2);
      tbl.push_back('{clr, en, qv, ph, oh, v, il, st, ho, sk, lk, err, err2});
   endtask

   task automatic model_step(input logic clr, en, input logic [3:0] qv);
      int k;
      if (clr) begin
         m_ph = 0; m_oh = 0; m_v = 0; m_il = 0; m_st = 0; m_ho = 0; m_sk = 0;
         m_state = 0; m_run = 0; m_ref_ok = 0; m_err = 0;
      end else if (!en) begin
         m_v = 0; m_il = 0; m_st = 0; m_ho = 0; m_sk = 0;
      end else begin
         k = -1;
         for (int i = 0; i < 8; i++) if (code_tab[i] == int'(qv)) k = i;
         m_v = 1; m_il = 0; m_st = 0; m_ho = 0; m_sk = 0;
         if (k < 0) begin
            m_il = 1; m_oh = 0; m_ref_ok = 0; m_err++; m_state = 0;
         end else begin
            if (m_ref_ok != 0) begin
               if (k == m_ph) m_ho = 1;
               else if (k == (m_ph + 1) % 8) m_st = 1;
               else begin m_sk = 1; m_err++; end
            end
            if (m_state == 0) begin
               m_state = 1; m_run = 0;
            end else if (m_state == 1) begin
               if (m_st != 0) begin
                  m_run++;
                  if (m_run == 4) m_state = 2;
               end else if (m_sk != 0) m_state = 0;
            end else if (m_sk != 0) m_state = 0;
            m_ph = k; m_oh = 1 << k; m_ref_ok = 1;
         end
      end
   endtask

   task automatic apply(input logic clr, en, input logic [3:0] qv);
      CLR = clr; EN = en; q = qv;
      @(posedge CLK);
      model_step(clr, en, qv);
      @(negedge CLK);
   endtask

   initial begin
      for (int k = 0; k < 8; k++)
         code_tab[k] = (k <= 4) ? ((1 << k) - 1) : (15 ^ ((1 << (k - 4)) - 1));
      model_step(1'b1, 1'b0, 4'b0);

      // reset
      row(1,1,4'b0101, 0,8'h00, 0,0,0,0,0,0, 0,0);
      row(1,0,4'b1111, 0,8'h00, 0,0,0,0,0,0, 0,0);
      // full forward sequence with wrap, lock on fifth sample
      row(0,1,4'b0000, 0,8'h01, 1,0,0,0,0,0, 0,0);
      row(0,1,4'b0001, 1,8'h02, 1,0,1,0,0,0, 0,0);
      row(0,1,4'b0011, 2,8'h04, 1,0,1,0,0,0, 0,0);
      row(0,1,4'b0111, 3,8'h08, 1,0,1,0,0,0, 0,0);
      row(0,1,4'b1111, 4,8'h10, 1,0,1,0,0,1, 0,0);
      row(0,1,4'b1110, 5,8'h20, 1,0,1,0,0,1, 0,0);
      row(0,1,4'b1100, 6,8'h40, 1,0,1,0,0,1, 0,0);
      row(0,1,4'b1000, 7,8'h80, 1,0,1,0,0,1, 0,0);
      row(0,1,4'b0000, 0,8'h01, 1,0,1,0,0,1, 0,0);
      row(0,1,4'b0001, 1,8'h02, 1,0,1,0,0,1, 0,0);
      row(0,1,4'b0011, 2,8'h04, 1,0,1,0,0,1, 0,0);
      row(0,1,4'b0111, 3,8'h08, 1,0,1,0,0,1, 0,0);
      // illegal while locked, then fresh reference
      row(0,1,4'b0101, 3,8'h00, 1,1,0,0,0,0, 1,1);
      row(0,1,4'b0111, 3,8'h08, 1,0,0,0,0,0, 1,1);
      // backward and forward skips
      row(0,1,4'b0011, 2,8'h04, 1,0,0,0,1,0, 2,2);
      row(0,1,4'b1111, 4,8'h10, 1,0,0,0,1,0, 3,3);
      row(0,1,4'b0111, 3,8'h08, 1,0,0,0,1,0, 4,3);
      // hold across idle cycles
      row(0,1,4'b0111, 3,8'h08, 1,0,0,1,0,0, 4,3);
      row(0,0,4'b1010, 3,8'h08, 0,0,0,0,0,0, 4,3);
      row(0,0,4'b0001, 3,8'h08, 0,0,0,0,0,0, 4,3);
      row(0,0,4'b0101, 3,8'h08, 0,0,0,0,0,0, 4,3);
      row(0,1,4'b0111, 3,8'h08, 1,0,0,1,0,0, 4,3);
      // clear, then saturation of the narrow counter
      row(1,1,4'b0011, 0,8'h00, 0,0,0,0,0,0, 0,0);
      row(0,1,4'b0101, 0,8'h00, 1,1,0,0,0,0, 1,1);
      row(0,1,4'b1010, 0,8'h00, 1,1,0,0,0,0, 2,2);
      row(0,1,4'b0010, 0,8'h00, 1,1,0,0,0,0, 3,3);
      row(0,1,4'b1001, 0,8'h00, 1,1,0,0,0,0, 4,3);
      row(0,1,4'b0100, 0,8'h00, 1,1,0,0,0,0, 5,3);
      row(1,1,4'b0001, 0,8'h00, 0,0,0,0,0,0, 0,0);

      @(negedge CLK);
      foreach (tbl[i]) begin
         apply(tbl[i].clr, tbl[i].en, tbl[i].qv);
         check($sformatf("vec%0d phase", i),   32'(phase),    32'(tbl[i].ph));
         check($sformatf("vec%0d onehot", i),  32'(onehot),   32'(tbl[i].oh));
         check($sformatf("vec%0d valid", i),   32'(valid),    32'(tbl[i].v));
         check($sformatf("vec%0d illegal", i), 32'(illegal),  32'(tbl[i].il));
         check($sformatf("vec%0d step", i),    32'(step),     32'(tbl[i].st));
         check($sformatf("vec%0d hold", i),    32'(hold),     32'(tbl[i].ho));
         check($sformatf("vec%0d skip", i),    32'(skip),     32'(tbl[i].sk));
         check($sformatf("vec%0d locked", i),  32'(locked),   32'(tbl[i].lk));
         check($sformatf("vec%0d err_cnt", i), 32'(err_cnt),  32'(tbl[i].err));
         check($sformatf("vec%0d err_sat", i), 32'(err_cnt2), 32'(tbl[i].err2));
      end

      for (int i = 0; i < 600; i++) begin
         logic       rc, re;
         logic [3:0] rq;
         int         sel;
         rc  = ($urandom_range(0, 39) == 0);
         re  = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 5);
         if (sel <= 2)      rq = 4'(code_tab[(m_ph + 1) % 8]);
         else if (sel == 3) rq = 4'(code_tab[m_ph]);
         else if (sel == 4) rq = 4'(code_tab[$urandom_range(0, 7)]);
         else               rq = 4'($urandom_range(0, 15));
         apply(rc, re, rq);
         check($sformatf("rnd%0d phase", i),   32'(phase),    32'(m_ph));
         check($sformatf("rnd%0d onehot", i),  32'(onehot),   32'(m_oh));
         check($sformatf("rnd%0d valid", i),   32'(valid),    32'(m_v));
         check($sformatf("rnd%0d illegal", i), 32'(illegal),  32'(m_il));
         check($sformatf("rnd%0d step", i),    32'(step),     32'(m_st));
         check($sformatf("rnd%0d hold", i),    32'(hold),     32'(m_ho));
         check($sformatf("rnd%0d skip", i),    32'(skip),     32'(m_sk));
         check($sformatf("rnd%0d locked", i),  32'(locked),   32'(m_state == 2));
         check($sformatf("rnd%0d err_cnt", i), 32'(err_cnt),  32'((m_err > 255) ? 255 : m_err));
         check($sformatf("rnd%0d err_sat", i), 32'(err_cnt2), 32'((m_err > 3) ? 3 : m_err));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
